// File: rtl/hazard_ctrl_if.sv
// Bundle of hazard-control signals between the pipeline datapath and the
// hazard/stall sequencer. The sequencer takes the slave view.
interface hazard_ctrl_if #(
   parameter int CNT_W = 32
);
   logic [4:0]       id_rs1;
   logic [4:0]       id_rs2;
   logic             id_use_rs1;
   logic             id_use_rs2;
   logic             ex_memread;
   logic [4:0]       ex_rd;
   logic             ex_md;
   logic             ex_redirect;
   logic             im_stall;
   logic             dm_stall;
   logic             pc_we;
   logic             ifid_we;
   logic             idex_we;
   logic             exmem_we;
   logic             memwb_we;
   logic             ifid_flush;
   logic             idex_flush;
   logic             exmem_flush;
   logic             md_busy;
   logic [CNT_W-1:0] stall_cnt;
   logic [CNT_W-1:0] flush_cnt;

   // Datapath side: supplies hazard sources, consumes enables and flushes.
   modport master (
      output id_rs1, id_rs2, id_use_rs1, id_use_rs2,
      output ex_memread, ex_rd, ex_md, ex_redirect,
      output im_stall, dm_stall,
      input  pc_we, ifid_we, idex_we, exmem_we, memwb_we,
      input  ifid_flush, idex_flush, exmem_flush,
      input  md_busy, stall_cnt, flush_cnt
   );

   // Sequener side: consumes hazard sources, drives enables and flushes.
   modport slave (
      input  id_rs1, id_rs2, id_use_rs1, id_use_rs2,
      input  ex_memread, ex_rd, ex_md, ex_redirect,
      input  im_stall, dm_stall,
      output pc_we, ifid_we, idex_we, exmem_we, memwb_we,
      output ifid_flush, idex_flush, exmem_flush,
      output md_busy, stall_cnt, flush_cnt
   );
endinterface

// File: rtl/hazard_ctrl.sv
// Pipeline hazard and stall sequencer for the 5-stage RV32 core.
// Owns all pipeline-register write enables and flushes: load-use bubbles,
// taken-redirect flushes, multi-cycle MUL/DIV occupancy of EX and global
// freezes from memory wait states. Also keeps stall/flush perf counters.
module hazard_ctrl #(
   parameter int MD_LATENCY = 4,
   parameter int CNT_W      = 32
) (
   input  logic          clk,
   input  logic          rst,
   hazard_ctrl_if.slave  bus
);

   localparam int MDC_W = $clog2(MD_LATENCY);

   typedef enum logic {
      RUN     = 1'b0,
      MD_BUSY = 1'b1
   } state_t;

   state_t             state_reg;
   logic [MDC_W-1:0]   md_cnt_reg;
   logic               md_granted_reg;
   logic [CNT_W-1:0]   stall_cnt_reg;
   logic [CNT_W-1:0]   flush_cnt_reg;

   logic               freeze;
   logic               load_use;
   logic               md_hold;
   logic               redirect_take;

   // Hazard detection terms.
   always_comb begin
      freeze   = bus.im_stall | bus.dm_stall;
      load_use = bus.ex_memread && (bus.ex_rd != 5'd0) &&
                 ((bus.id_use_rs1 && (bus.id_rs1 == bus.ex_rd)) ||
                  (bus.id_use_rs2 && (bus.id_rs2 == bus.ex_rd)));
      md_hold  = (state_reg == MD_BUSY) ||
                 ((state_reg == RUN) && bus.ex_md && !md_granted_reg);
      // A redirect only lands when nothing of higher priority masks it.
      redirect_take = !rst && !freeze && !md_hold && bus.ex_redirect;
   end

   // Prioritised enable/flush generation, purely combinational.
   always_comb begin
      bus.pc_we       = 1'b1;
      bus.ifid_we     = 1'b1;
      bus.idex_we     = 1'b1;
      bus.exmem_we    = 1'b1;
      bus.memwb_we    = 1'b1;
      bus.ifid_flush  = 1'b0;
      bus.idex_flush  = 1'b0;
      bus.exmem_flush = 1'b0;
      if (rst) begin
         bus.pc_we       = 1'b0;
         bus.ifid_we     = 1'b0;
         bus.idex_we     = 1'b0;
         bus.exmem_we    = 1'b0;
         bus.memwb_we    = 1'b0;
         bus.ifid_flush  = 1'b1;
         bus.idex_flush  = 1'b1;
         bus.exmem_flush = 1'b1;
      end else if (freeze) begin
         // Whole pipe holds; redirect or load-use waits for the thaw.
         bus.pc_we    = 1'b0;
         bus.ifid_we  = 1'b0;
         bus.idex_we  = 1'b0;
         bus.exmem_we = 1'b0;
         bus.memwb_we = 1'b0;
      end else if (md_hold) begin
         // Front end and EX hold; a bubble goes to MEM so older ops drain.
         bus.pc_we       = 1'b0;
         bus.ifid_we     = 1'b0;
         bus.idex_we     = 1'b0;
         bus.exmem_flush = 1'b1;
      end else if (bus.ex_redirect) begin
         bus.ifid_flush = 1'b1;
         bus.idex_flush = 1'b1;
      end else if (load_use) begin
         bus.pc_we      = 1'b0;
         bus.ifid_we    = 1'b0;
         bus.idex_flush = 1'b1;
      end
   end

   assign bus.md_busy   = (state_reg == MD_BUSY);
   assign bus.stall_cnt = stall_cnt_reg;
   assign bus.flush_cnt = flush_cnt_reg;

   // MUL/DIV occupancy FSM, grant flag and performance counters.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_reg      <= RUN;
         md_cnt_reg     <= '0;
         md_granted_reg <= 1'b0;
         stall_cnt_reg  <= '0;
         flush_cnt_reg  <= '0;
      end else begin
         if (!bus.pc_we)
            stall_cnt_reg <= stall_cnt_reg + 1'b1;
         if (redirect_take)
            flush_cnt_reg <= flush_cnt_reg + 1'b1;

         case (state_reg)
            RUN: begin
               if (bus.ex_md && !md_granted_reg && !freeze) begin
                  state_reg  <= MD_BUSY;
                  md_cnt_reg <= MDC_W'(MD_LATENCY - 3);
               end
            end
            MD_BUSY: begin
               // The MD unit keeps computing through a freeze.
               if (md_cnt_reg != '0)
                  md_cnt_reg <= md_cnt_reg - 1'b1;
               if ((md_cnt_reg == '0) && !freeze) begin
                  state_reg      <= RUN;
                  md_granted_reg <= 1'b1;
               end
            end
            default: state_reg <= RUN;
         endcase

         // The granted op leaves EX on the first cycle EX is allowed to load.
         if (bus.idex_we)
            md_granted_reg <= 1'b0;
      end
   end

endmodule
